// File: rtl/vector_exec_sequencer.sv
// Issue-side sequencer for the vector lanes: accepts one op per cycle, reserves a
// writeback slot in a pending pipeline so at most one operation completes per cycle.
module vector_exec_sequencer #(
  parameter int REGISTER_NUMBERS = 32,
  parameter int SIMPLE_LATENCY   = 1,
  parameter int MUL_LATENCY      = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                issue_valid,
  input  logic                                issue_mul,
  input  logic [$clog2(REGISTER_NUMBERS)-1:0] issue_dest,
  output logic                                issue_ready,
  input  logic                                flush,
  output logic                                exec_start,
  output logic                                exec_mul,
  output logic [$clog2(REGISTER_NUMBERS)-1:0] exec_dest,
  output logic                                operation_done,
  output logic [$clog2(REGISTER_NUMBERS)-1:0] alu_dest,
  output logic                                busy
);

  localparam int DW = $clog2(REGISTER_NUMBERS);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t        state, state_next;
  logic [3:0]    mul_cnt, mul_cnt_next;
  logic          pend_v    [MUL_LATENCY];
  logic [DW-1:0] pend_dest [MUL_LATENCY];
  logic          accept;
  logic          any_pend;

  // A simple op lands in pend[SIMPLE_LATENCY-1], which is fed by pend[SIMPLE_LATENCY] on the shift.
  assign issue_ready = !flush && (issue_mul ? (state == IDLE) : !pend_v[SIMPLE_LATENCY]);
  assign accept      = issue_valid && issue_ready;

  assign exec_start  = accept;
  assign exec_mul    = issue_mul;
  assign exec_dest   = issue_dest;

  assign operation_done = pend_v[0];
  assign alu_dest       = pend_v[0] ? pend_dest[0] : '0;

  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < MUL_LATENCY; i++) any_pend = any_pend | pend_v[i];
  end

  assign busy = any_pend || (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pend_v[i]    <= 1'b0;
        pend_dest[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pend_v[i]    <= 1'b0;
        pend_dest[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MUL_LATENCY - 1; i++) begin
        pend_v[i]    <= pend_v[i+1];
        pend_dest[i] <= pend_dest[i+1];
      end
      pend_v[MUL_LATENCY-1]    <= 1'b0;
      pend_dest[MUL_LATENCY-1] <= '0;
      // The accepted op overrides whatever the shift would have placed in its slot.
      if (accept) begin
        if (issue_mul) begin
          pend_v[MUL_LATENCY-1]    <= 1'b1;
          pend_dest[MUL_LATENCY-1] <= issue_dest;
        end else begin
          pend_v[SIMPLE_LATENCY-1]    <= 1'b1;
          pend_dest[SIMPLE_LATENCY-1] <= issue_dest;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Multiplier occupancy: frees up in time for the next multiply to issue as the previous one completes.
  always_comb begin
    state_next   = state;
    mul_cnt_next = mul_cnt;
    if (flush) begin
      state_next   = IDLE;
      mul_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && issue_mul) begin
            state_next   = MUL_BUSY;
            mul_cnt_next = 4'd1;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt == 4'(MUL_LATENCY - 1)) begin
            state_next   = IDLE;
            mul_cnt_next = '0;
          end else begin
            mul_cnt_next = mul_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Directed table-driven bench for vector_exec_sequencer with default parameters
// (SIMPLE_LATENCY=1, MUL_LATENCY=4), plus hand sequences for reset corner cases.
module tb_vector_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_mul, flush;
  logic [4:0] issue_dest;
  logic       issue_ready, exec_start, exec_mul, operation_done, busy;
  logic [4:0] exec_dest, alu_dest;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic       v, m;
    logic [4:0] d;
    logic       f;
    logic       er, es, od;
    logic [4:0] ad;
    logic       bz;
  } vec_t;

  vec_t tbl[$];

  vector_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_mul(issue_mul), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .flush(flush),
    .exec_start(exec_start), .exec_mul(exec_mul), .exec_dest(exec_dest),
    .operation_done(operation_done), .alu_dest(alu_dest), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void addVector(logic v, logic m, logic [4:0] d, logic f,
                                    logic er, logic es, logic od, logic [4:0] ad, logic bz);
    vec_t e;
    e.v = v; e.m = m; e.d = d; e.f = f;
    e.er = er; e.es = es; e.od = od; e.ad = ad; e.bz = bz;
    tbl.push_back(e);
  endfunction

  task automatic applyStimulus(logic v, logic m, logic [4:0] d, logic f);
    issue_valid = v;
    issue_mul   = m;
    issue_dest  = d;
    flush       = f;
  endtask

  // Output word layout: {issue_ready, exec_start, exec_mul, exec_dest, operation_done, alu_dest, busy}
  task automatic checkOutput(string name, logic [14:0] exp);
    logic [14:0] got;
    got = {issue_ready, exec_start, exec_mul, exec_dest, operation_done, alu_dest, busy};
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got rdy=%b start=%b mul=%b edst=%0d done=%b adst=%0d busy=%b, want rdy=%b start=%b mul=%b edst=%0d done=%b adst=%0d busy=%b",
               name, got[14], got[13], got[12], got[11:7], got[6], got[5:1], got[0],
               exp[14], exp[13], exp[12], exp[11:7], exp[6], exp[5:1], exp[0]);
    end
  endtask

  initial begin
    // Single simple op, dest 5
    addVector(1,0,5,0,  1,1,0,0,0);
    addVector(0,0,0,0,  1,0,1,5,1);
    addVector(0,0,0,0,  1,0,0,0,0);
    // Mul 3, then mul 4 held until the multiplier frees
    addVector(1,1,3,0,  1,1,0,0,0);
    addVector(1,1,4,0,  0,0,0,0,1);
    addVector(1,1,4,0,  0,0,0,0,1);
    addVector(1,1,4,0,  0,0,0,0,1);
    addVector(1,1,4,0,  1,1,1,3,1);
    addVector(0,0,0,0,  1,0,0,0,1);
    addVector(0,0,0,0,  1,0,0,0,1);
    addVector(0,0,0,0,  0,0,0,0,1);
    addVector(0,0,0,0,  1,0,1,4,1);
    addVector(0,0,0,0,  1,0,0,0,0);
    // Mul 2 with simple ops 7,8,9; 9 collides with the mul writeback once
    addVector(1,1,2,0,  1,1,0,0,0);
    addVector(1,0,7,0,  1,1,0,0,1);
    addVector(1,0,8,0,  1,1,1,7,1);
    addVector(1,0,9,0,  0,0,1,8,1);
    addVector(1,0,9,0,  1,1,1,2,1);
    addVector(0,0,0,0,  1,0,1,9,1);
    addVector(0,0,0,0,  1,0,0,0,0);
    // Flush with mul 6 and simple 1 in flight, then a fresh mul 10
    addVector(1,1,6,0,  1,1,0,0,0);
    addVector(1,0,1,0,  1,1,0,0,1);
    addVector(1,0,11,1, 0,0,1,1,1);
    addVector(1,1,10,0, 1,1,0,0,0);
    addVector(0,0,0,0,  1,0,0,0,1);
    addVector(0,0,0,0,  1,0,0,0,1);
    addVector(0,0,0,0,  0,0,0,0,1);
    addVector(0,0,0,0,  1,0,1,10,1);
    addVector(0,0,0,0,  1,0,0,0,0);

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("reset_idle", {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i].v, tbl[i].m, tbl[i].d, tbl[i].f);
      #1 checkOutput($sformatf("vec%0d", i),
                     {tbl[i].er, tbl[i].es, tbl[i].m, tbl[i].d, tbl[i].od, tbl[i].ad, tbl[i].bz});
    end

    // Async reset two cycles into a multiply must drop it completely
    @(negedge clk);
    applyStimulus(1, 1, 12, 0);
    #1 checkOutput("rst_mul_accept", {1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0});
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    #1 checkOutput("rst_mul_busy", {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_mul", {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("post_rst%0d", k), {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_exec_sequencer.md
Name: vector_exec_sequencer

Overview:
- Issue-side controller for the vector lane execution unit. Sits between the vector dispatch scoreboard and the lanes.
- Accepts one issued lane operation per cycle and starts it in the lanes.
- Schedules the writeback slot so that at most one completion occurs per cycle.
- Generates the operation_done / alu_dest pair that the scoreboard uses to release destination registers.
- Simple ops are fully pipelined. Multiplies are non-pipelined and block further multiplies while the multiplier is busy.

Parameters:
REGISTER_NUMBERS, 32, number of vector registers; dest fields are $clog2(REGISTER_NUMBERS) bits
SIMPLE_LATENCY, 1, cycles from accept to operation_done for non-multiply ops; range 1..MUL_LATENCY-1
MUL_LATENCY, 4, cycles from accept to operation_done for multiply ops; 2..15

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  scoreboard presents an operation
issue_mul  input  1  operation is a multiply-class op (vmul/vmacc/vmadd family)
issue_dest  input  $clog2(REGISTER_NUMBERS)  destination vector register
issue_ready  output  1  sequencer accepts the operation this cycle
flush  input  1  discard all in-flight operations
exec_start  output  1  start pulse to lanes
exec_mul  output  1  route to multiplier
exec_dest  output  $clog2(REGISTER_NUMBERS)  dest tag to lanes
operation_done  output  1  one operation completes this cycle
alu_dest  output  $clog2(REGISTER_NUMBERS)  dest of completing operation
busy  output  1  any operation in flight or multiplier occupied

Behaviour:
- Reset (rst_n low, async):
  - pending pipeline cleared, FSM=IDLE, mul counter=0.
  - operation_done=0, alu_dest=0, exec_start=0, busy=0.
  - issue_ready is combinational and is 0 while flush=1.
  - Reset mid-operation drops every in-flight op; no done is ever produced for it.
- Pending pipeline: MUL_LATENCY entries pend[0..MUL_LATENCY-1], each holding {v, dest}.
  - Every edge: pend[i] <= pend[i+1]; pend[MUL_LATENCY-1] <= 0.
- Accept = issue_valid && issue_ready (registered as a transfer at the next edge).
  - Accept in cycle t with latency L writes {1, issue_dest} into pend[L-1] at that edge, overriding the shift.
  - operation_done is therefore asserted exactly during cycle t+L.
- Outputs from the pending pipeline: operation_done = pend[0].v. alu_dest = pend[0].dest when pend[0].v, else 0.
- exec_start = accept (combinational). exec_mul = issue_mul. exec_dest = issue_dest.
- issue_ready = !flush && (issue_mul ? (fsm==IDLE) : !pend[SIMPLE_LATENCY].v).
  - issue_ready depends on issue_mul by design.
  - A multiply slot pend[MUL_LATENCY-1] is always free after the shift, so only the FSM gates it.
- FSM:
  - IDLE -> MUL_BUSY on accept with issue_mul; counter <= 1.
  - MUL_BUSY: counter increments each cycle. When counter==MUL_LATENCY-1, FSM -> IDLE and counter <= 0.
  - The next multiply can therefore be accepted in cycle t+MUL_LATENCY, the same cycle the previous one completes.
  - Simple ops are accepted during MUL_BUSY whenever their slot is free.
- flush (synchronous):
  - At the edge, clear all pend entries, FSM -> IDLE, counter <= 0.
  - No accept in the flush cycle.
  - operation_done still reflects pend[0] during the flush cycle; that done is valid.
- busy = OR of all pend[i].v, or FSM != IDLE.
- Back-to-back simple ops: one accepted every cycle, dones in order, one per cycle.
- A simple op issued after a multiply may complete before it. Out-of-order completion is legal; the scoreboard tracks by dest.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> operation_done=0, alu_dest=0, busy=0, issue_ready=1 for a simple op.
- Simple op dest=5 accepted cycle 10 (SIMPLE_LATENCY=1) -> exec_start=1 at cycle 10; operation_done=1, alu_dest=5 only at cycle 11.
- Mul dest=3 accepted cycle 10 (MUL_LATENCY=4), mul dest=4 presented from cycle 11 -> issue_ready=0 for cycles 11-13; second mul accepted cycle 14; done dest=3 at 14, done dest=4 at 18.
- Mul dest=2 at cycle 0, simple ops dest=7,8,9 at cycles 1,2,3 -> simple op at cycle 3 refused (slot collides with the mul completing at 4) and accepted at 4. Dones: 7@2, 8@3, 2@4, 9@5. Never two dones in one cycle.
- Flush at cycle 2 with mul dest=6 (accepted 0) and simple dest=1 (accepted 1) in flight -> done dest=1 still seen at cycle 2; no done for 6; busy=0 at cycle 3; new mul accepted cycle 3.
- Async reset asserted mid-mul (cycle 2 of 4) -> outputs 0 immediately; no stale done after release.
